param_rom_stream_arbiter: RTL

PARAM_ROM_STREAM_ARBITER -- requirements
Module: param_rom_stream_arbiter

---
 rtl/param_rom_arb_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/param_rom_stream_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/param_rom_arb_pkg.sv
// ============================================================================
// Module      : param_rom_arb_pkg
// Description : Shared state encoding and ROM timing for the parameter ROM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package param_rom_arb_pkg;

  localparam int ROM_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } arb_state_t;

  // Pointer width that stays legal for a single requester.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin pick; search starts one above the last owner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import param_rom_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   last,
  output logic [NUM_REQ-1:0] grant
);

  logic [NUM_REQ-1:0] w_sel;
  int                 w_best_d;

  // Distance above the last owner; the closest requester wins.
  always_comb begin
    w_sel    = '0;
    w_best_d = NUM_REQ;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (req[j] && (((j - int'(last) - 1 + 2 * NUM_REQ) % NUM_REQ) < w_best_d)) begin
        w_best_d = (j - int'(last) - 1 + 2 * NUM_REQ) % NUM_REQ;
        w_sel    = '0;
        w_sel[j] = 1'b1;
      end
    end
  end

  assign grant = w_sel;

endmodule

`default_nettype wire

// File: rtl/param_rom_stream_arbiter.sv
// ============================================================================
// Module      : param_rom_stream_arbiter
// Description : Shares one 2-cycle-latency parameter ROM among requesters,
//               streaming a full DEPTH-word pass per grant with backpressure.
//               Optional macro PARAM_ROM_ARB_HOLD_EN keeps the grant while
//               the owner still requests.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_rom_stream_arbiter
  import param_rom_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 24,
  parameter int ADDR_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_ce,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [NUM_REQ-1:0]    data_out_valid,
  input  logic [NUM_REQ-1:0]    data_out_ready
);

  localparam int                    c_ptr_w     = ptr_width(NUM_REQ);
  localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(DEPTH - 1);

  logic [1:0]             r_rst_sync;
  logic                   w_rst_n;
  arb_state_t             r_state;
  arb_state_t             w_state_nxt;
  logic [NUM_REQ-1:0]     r_grant;
  logic [NUM_REQ-1:0]     r_done;
  logic [c_ptr_w-1:0]     r_owner;
  logic [c_ptr_w-1:0]     r_ptr;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [ROM_LATENCY-1:0] r_v;
  logic [NUM_REQ-1:0]     w_arb_grant;
  logic [c_ptr_w-1:0]     w_arb_idx;
  logic                   w_stall;
  logic                   w_ce;
  logic                   w_issue;
  logic                   w_pass_end;
  logic                   w_hold;

  // Assert immediately, release two edges later so the first active edge is clean.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rst_sync <= 2'b00;
    else      r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (c_ptr_w)
  ) u_rr_arbiter (
    .req   (req),
    .last  (r_ptr),
    .grant (w_arb_grant)
  );

  always_comb begin
    w_arb_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_arb_grant[i]) w_arb_idx = c_ptr_w'(i);
    end
  end

`ifdef PARAM_ROM_ARB_HOLD_EN
  assign w_hold = req[r_owner];
`else
  assign w_hold = 1'b0;
`endif

  assign w_stall    = r_v[ROM_LATENCY-1] & ~data_out_ready[r_owner];
  assign w_ce       = (r_state != IDLE) & ~w_stall;
  assign w_issue    = (r_state == STREAM);
  // Pass ends on the edge that retires the last word from an otherwise empty pipe.
  assign w_pass_end = (r_state == DRAIN) & ~(|r_v[ROM_LATENCY-2:0])
                    & (~r_v[ROM_LATENCY-1] | w_ce);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (|req) w_state_nxt = STREAM;
      STREAM:  if (w_ce && (r_addr == c_last_addr)) w_state_nxt = DRAIN;
      DRAIN:   if (w_pass_end) w_state_nxt = w_hold ? STREAM : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_grant <= '0;
      r_done  <= '0;
      r_owner <= '0;
      r_ptr   <= c_ptr_w'(NUM_REQ - 1);
      r_addr  <= '0;
      r_v     <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_grant <= w_arb_grant;
            r_owner <= w_arb_idx;
            r_ptr   <= w_arb_idx;
            r_addr  <= '0;
          end
        end
        STREAM, DRAIN: begin
          if (w_ce) begin
            r_v <= {r_v[ROM_LATENCY-2:0], w_issue};
            if (w_issue && (r_addr != c_last_addr)) r_addr <= r_addr + ADDR_WIDTH'(1);
          end
          if (w_pass_end) begin
            r_done <= r_grant;
            r_addr <= '0;
            if (!w_hold) r_grant <= '0;
          end
        end
        default: r_grant <= '0;
      endcase
    end
  end

  assign grant          = r_grant;
  assign done           = r_done;
  assign rom_addr       = r_addr;
  assign rom_ce         = w_ce;
  assign data_out       = rom_q;
  assign data_out_valid = r_v[ROM_LATENCY-1] ? r_grant : '0;

endmodule

`default_nettype wire
